// File: rtl/fetch_sequencer.sv
// Instruction fetch/control sequencer: steps an external TTL-style pc, fetches and decodes store words,
// offers data ops to the execute unit and resolves JMP/JRP/CMP/STP itself. Optional macro: SINGLE_STEP_EN.
module fetch_sequencer #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int OP_LSB        = 13,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic                  RUN,
`ifdef SINGLE_STEP_EN
  input  logic                  STEP,
`endif
  input  logic [WORD_WIDTH-1:0] PC_Q,
  output logic                  PC_OE_n,
  output logic                  PC_LOAD_n,
  output logic [WORD_WIDTH-1:0] PC_A,
  output logic                  PC_CLK,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_RD,
  input  logic                  MEM_ACK,
  input  logic [WORD_WIDTH-1:0] MEM_DATA,
  input  logic                  ACC_NEG,
  output logic                  EXEC_VALID,
  output logic [2:0]            EXEC_OP,
  output logic [ADDR_WIDTH-1:0] EXEC_ADDR,
  input  logic                  EXEC_DONE,
  output logic                  HALTED
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [2:0] OP_JMP = 3'b000;
  localparam logic [2:0] OP_JRP = 3'b001;
  localparam logic [2:0] OP_LDN = 3'b010;
  localparam logic [2:0] OP_STO = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SUBA = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_STP = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_INC, S_READPC, S_FETCH, S_DECODE, S_EXEC,
    S_OPFETCH, S_LOAD, S_LOADCLK, S_SKIP, S_HALT
  } state_t;

  state_t                state, next_state;
  logic [CW-1:0]         settle_cnt;
  logic                  settle_last;
  logic [WORD_WIDTH-1:0] ci_reg;
  logic [2:0]            ir_op;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic                  run_seen_low;
  logic                  mem_ack;
  logic                  step_ok;

  assign settle_last = (settle_cnt == CW'(SETTLE_CYCLES - 1));
  // An acknowledge only counts while a read is actually outstanding.
  assign mem_ack     = MEM_ACK & MEM_RD;

`ifdef SINGLE_STEP_EN
  logic step_q, step_pend;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q <= STEP;
      if (STEP && !step_q)
        step_pend <= 1'b1;
      else if (state == S_IDLE && next_state == S_INC)
        step_pend <= 1'b0;
    end
  end

  assign step_ok = step_pend;
`else
  assign step_ok = 1'b1;
`endif

  // NOTE: next_state gets its default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    if (RUN && step_ok) next_state = S_INC;
      S_INC:     next_state = S_READPC;
      S_READPC:  if (settle_last) next_state = S_FETCH;
      S_FETCH:   if (mem_ack) next_state = S_DECODE;
      S_DECODE: begin
        unique case (ir_op)
          OP_LDN, OP_STO, OP_SUB, OP_SUBA: next_state = S_EXEC;
          OP_JMP, OP_JRP:                  next_state = S_OPFETCH;
          OP_CMP:                          next_state = ACC_NEG ? S_SKIP : S_IDLE;
          OP_STP:                          next_state = S_HALT;
          default:                         next_state = S_IDLE;
        endcase
      end
      S_EXEC:    if (EXEC_DONE) next_state = S_IDLE;
      S_OPFETCH: if (mem_ack) next_state = S_LOAD;
      S_LOAD:    next_state = S_LOADCLK;
      S_LOADCLK: next_state = S_IDLE;
      S_SKIP:    next_state = S_IDLE;
      S_HALT:    if (run_seen_low && RUN) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so every strobe leaves a flop glitch-free.
  // NOTE: all state and registered outputs use non-blocking assignments so flops update together.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state        <= S_IDLE;
      PC_OE_n      <= 1'b1;
      PC_LOAD_n    <= 1'b1;
      PC_CLK       <= 1'b0;
      PC_A         <= '0;
      MEM_ADDR     <= '0;
      MEM_RD       <= 1'b0;
      EXEC_VALID   <= 1'b0;
      EXEC_OP      <= '0;
      EXEC_ADDR    <= '0;
      HALTED       <= 1'b0;
      settle_cnt   <= '0;
      ci_reg       <= '0;
      ir_op        <= '0;
      ir_addr      <= '0;
      run_seen_low <= 1'b0;
    end else begin
      state        <= next_state;
      PC_CLK       <= (next_state inside {S_INC, S_LOADCLK, S_SKIP});
      PC_OE_n      <= (next_state != S_READPC);
      PC_LOAD_n    <= !(next_state inside {S_LOAD, S_LOADCLK});
      MEM_RD       <= (next_state inside {S_FETCH, S_OPFETCH});
      EXEC_VALID   <= (next_state == S_EXEC);
      HALTED       <= (next_state == S_HALT);
      settle_cnt   <= (state == S_READPC) ? settle_cnt + 1'b1 : '0;
      run_seen_low <= (state == S_HALT) && (run_seen_low || !RUN);

      // Only the low address bits select a store line; upper pc bits are kept for JRP arithmetic.
      if (state == S_READPC && settle_last) begin
        ci_reg   <= PC_Q;
        MEM_ADDR <= PC_Q[ADDR_WIDTH-1:0];
      end

      if (state == S_FETCH && mem_ack) begin
        ir_op   <= MEM_DATA[OP_LSB+2:OP_LSB];
        ir_addr <= MEM_DATA[ADDR_WIDTH-1:0];
      end

      if (state == S_DECODE && next_state == S_EXEC) begin
        EXEC_OP   <= ir_op;
        EXEC_ADDR <= ir_addr;
      end

      if (state == S_DECODE && next_state == S_OPFETCH)
        MEM_ADDR <= ir_addr;

      if (state == S_OPFETCH && mem_ack)
        PC_A <= (ir_op == OP_JRP) ? ci_reg + MEM_DATA : MEM_DATA;
    end
  end

endmodule
